dmem_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache placed between the MIPS core's load/store port and a slow multi-cycle data memory.
- Hits are serviced combinationally, with no stall.
- Misses assert proc_stall and run a writeback/allocate sequence over a block-wide memory handshake.
- This lets the core move from the single-cycle SRAM model to a realistic memory with latency.

---
 rtl/dmem_cache_if.sv | 34 +++
 rtl/dmem_cache.sv | 148 ++++++++++++++
 tb/tb_dmem_cache.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_cache_if.sv
// ---------------------------------------------------------------------------
// dmem_cache_if : core load/store port plus block-wide memory handshake
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dmem_cache_if #(
  parameter int AW = 30
);
  logic          proc_read;
  logic          proc_write;
  logic [AW-1:0] proc_addr;
  logic [31:0]   proc_wdata;
  logic [31:0]   proc_rdata;
  logic          proc_stall;
  logic          mem_read;
  logic          mem_write;
  logic [AW-3:0] mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_cache.sv
// ---------------------------------------------------------------------------
// dmem_cache : direct-mapped write-back/write-allocate data cache
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_cache #(
  parameter int LINES = 8,
  parameter int WORDS = 4,
  parameter int AW    = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_cache_if.slave   bus
);
  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(WORDS);
  localparam int TW = AW - IW - OW;
  localparam int LW = WORDS * 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [LW-1:0]    data_mem [LINES];

  logic [TW-1:0] req_tag;
  logic [IW-1:0] idx;
  logic [OW-1:0] off;
  logic [LW-1:0] line;
  logic          req;
  logic          hit;
  logic          wr_hit;
  logic          fill;
  logic          wb_done;

  logic          stall;
  logic          mem_read;
  logic          mem_write;
  logic [AW-3:0] mem_addr;
  logic [LW-1:0] mem_wdata;

  assign req_tag = bus.proc_addr[AW-1:IW+OW];
  assign idx     = bus.proc_addr[IW+OW-1:OW];
  assign off     = bus.proc_addr[OW-1:0];
  assign line    = data_mem[idx];
  assign req     = bus.proc_read | bus.proc_write;
  assign hit     = valid[idx] & (tag_mem[idx] == req_tag);

  // Load data is always presented; it is only meaningful on a hit in IDLE.
  assign bus.proc_rdata = line[{off, 5'b0} +: 32];
  assign bus.proc_stall = stall;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_hit     = 1'b0;
    fill       = 1'b0;
    wb_done    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            wr_hit = bus.proc_write;
          end else begin
            stall      = 1'b1;
            state_next = (valid[idx] & dirty[idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {tag_mem[idx], idx};
        mem_wdata = line;
        if (bus.mem_ready) begin
          wb_done    = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = bus.proc_addr[AW-1:OW];
        if (bus.mem_ready) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (wr_hit) begin
        dirty[idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty[idx] <= 1'b0;
      end
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays need no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill) begin
        tag_mem[idx]  <= req_tag;
        data_mem[idx] <= bus.mem_rdata;
      end else if (wr_hit) begin
        data_mem[idx][{off, 5'b0} +: 32] <= bus.proc_wdata;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_dmem_cache.sv
// ---------------------------------------------------------------------------
// tb_dmem_cache : directed stimulus with queued expectations for dmem_cache
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_cache;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_cache_if #(.AW(30)) bus ();

  dmem_cache #(.LINES(8), .WORDS(4), .AW(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mtxn_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  mtxn_t       exp_mem[$];
  logic [31:0] exp_rd[$];
  logic [127:0] bmem [logic [27:0]];
  bit          mem_en  = 1'b1;
  int          lat_cnt = 0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  mtxn_t       mon_e;
  logic [31:0] mon_d;

  // Untouched block b holds word i = {b[15:0]^16'h0004, i}; block 4 reads 3,2,1,0.
  function automatic logic [127:0] blk_init(input logic [27:0] b);
    logic [15:0] h;
    h = b[15:0] ^ 16'h0004;
    return {h, 16'd3, h, 16'd2, h, 16'd1, h, 16'd0};
  endfunction

  function automatic mtxn_t mk(input logic wr, input logic [27:0] a, input logic [127:0] d);
    mtxn_t t;
    t.wr = wr; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: answers each request on its third cycle; writebacks update backing store.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (rst_n && mem_en && (bus.mem_read || bus.mem_write)) begin
        lat_cnt++;
        if (lat_cnt == 3) begin
          lat_cnt = 0;
          bus.mem_ready = 1'b1;
          if (bus.mem_write) bmem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = bmem.exists(bus.mem_addr) ? bmem[bus.mem_addr]
                                                        : blk_init(bus.mem_addr);
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Monitor: pops an expectation at each memory transaction start and each completed load.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (bus.mem_read || bus.mem_write)
        check("mem_excl", {bus.mem_read, bus.mem_write} == 2'b11, 1'b0);
      if ((bus.mem_read && !prev_rd) || (bus.mem_write && !prev_wr)) begin
        if (exp_mem.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mem_txn: got unexpected rd=%0b wr=%0b addr=%h, expected none",
                   bus.mem_read, bus.mem_write, bus.mem_addr);
        end else begin
          mon_e = exp_mem.pop_front();
          check("mem_kind", bus.mem_write, mon_e.wr);
          check("mem_addr", bus.mem_addr, mon_e.addr);
          if (mon_e.wr) check("mem_wdata", bus.mem_wdata, mon_e.wdata);
        end
      end
      prev_rd = bus.mem_read;
      prev_wr = bus.mem_write;
      if (bus.proc_read && !bus.proc_write && !bus.proc_stall) begin
        if (exp_rd.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL load: got unexpected data %h, expected none", bus.proc_rdata);
        end else begin
          mon_d = exp_rd.pop_front();
          check("load_data", bus.proc_rdata, mon_d);
        end
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] d, input int exp_stalls, input string name);
    int st;
    bit done;
    st = 0; done = 1'b0;
    @(posedge clk); #1;
    bus.proc_read = rd; bus.proc_write = wr; bus.proc_addr = a; bus.proc_wdata = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.proc_stall) st++;
      else done = 1'b1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got stall still high after 50 cycles, expected release", name);
    end else begin
      check({name, "_stalls"}, st, exp_stalls);
    end
    @(posedge clk); #1;
    bus.proc_read = 1'b0; bus.proc_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.proc_read = 1'b0; bus.proc_write = 1'b0;
    bus.proc_addr = '0;   bus.proc_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall", bus.proc_stall, 1'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);

    // Cold read miss, then hits on the same line
    exp_mem.push_back(mk(1'b0, 28'h4, '0)); exp_rd.push_back(32'h0);
    access(1, 0, 30'h10, 0, 4, "rd10_miss");
    exp_rd.push_back(32'h3);
    access(1, 0, 30'h13, 0, 0, "rd13_hit");
    access(0, 1, 30'h11, 32'hDEADBEEF, 0, "wr11_hit");
    exp_rd.push_back(32'hDEADBEEF);
    access(1, 0, 30'h11, 0, 0, "rd11_hit");

    // Dirty conflict: writeback then fill of block 0xC
    exp_mem.push_back(mk(1'b1, 28'h4, {32'h3, 32'h2, 32'hDEADBEEF, 32'h0}));
    exp_mem.push_back(mk(1'b0, 28'hC, '0)); exp_rd.push_back(32'h0008_0000);
    access(1, 0, 30'h30, 0, 7, "rd30_dirty");

    // Clean conflict: straight to fill
    exp_mem.push_back(mk(1'b0, 28'h14, '0)); exp_rd.push_back(32'h0010_0000);
    access(1, 0, 30'h50, 0, 4, "rd50_clean");

    // Written-back block comes back from memory
    exp_mem.push_back(mk(1'b0, 28'h4, '0)); exp_rd.push_back(32'hDEADBEEF);
    access(1, 0, 30'h11, 0, 4, "rd11_refetch");
    exp_rd.push_back(32'h2);
    access(1, 0, 30'h12, 0, 0, "rd12_hit");

    // Write miss allocates and merges word 0
    exp_mem.push_back(mk(1'b0, 28'h9, '0));
    access(0, 1, 30'h24, 32'hCAFEF00D, 4, "wr24_miss");
    exp_rd.push_back(32'hCAFEF00D);
    access(1, 0, 30'h24, 0, 0, "rd24_hit");
    exp_rd.push_back(32'h000D_0001);
    access(1, 0, 30'h25, 0, 0, "rd25_hit");
    exp_rd.push_back(32'h000D_0003);
    access(1, 0, 30'h27, 0, 0, "rd27_hit");

    // That line is dirty: evicting it writes the merged block
    exp_mem.push_back(mk(1'b1, 28'h9, {32'h000D_0003, 32'h000D_0002, 32'h000D_0001, 32'hCAFEF00D}));
    exp_mem.push_back(mk(1'b0, 28'h11, '0)); exp_rd.push_back(32'h0015_0000);
    access(1, 0, 30'h44, 0, 7, "rd44_dirty");

    // Read and write together behave as a write
    access(1, 1, 30'h45, 32'h1234_5678, 0, "rdwr45_hit");
    exp_rd.push_back(32'h1234_5678);
    access(1, 0, 30'h45, 0, 0, "rd45_hit");

    // Reset during an ALLOCATE wait
    mem_en = 1'b0;
    exp_mem.push_back(mk(1'b0, 28'h1C, '0));
    @(posedge clk); #1;
    bus.proc_read = 1'b1; bus.proc_addr = 30'h70;
    repeat (3) @(negedge clk);
    check("alloc_wait_mem_read", bus.mem_read, 1'b1);
    check("alloc_wait_stall", bus.proc_stall, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.proc_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_mem_read", bus.mem_read, 1'b0);
    check("post_rst_stall", bus.proc_stall, 1'b0);
    mem_en = 1'b1;
    exp_mem.push_back(mk(1'b0, 28'h4, '0)); exp_rd.push_back(32'h2);
    access(1, 0, 30'h12, 0, 4, "rd12_after_rst");

    repeat (5) @(posedge clk);
    check("exp_mem_drained", exp_mem.size(), 0);
    check("exp_rd_drained", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
